// File: rtl/x_stream_gen.sv
// Serial burst generator: emits `reps` bursts of `len` ones separated by `gap`
// zeros, then pulses done for one cycle. All outputs come straight from flops.
module x_stream_gen (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] len,
    input  logic [3:0] gap,
    input  logic [3:0] reps,
    output logic       X,
    output logic       busy,
    output logic       done,
    output logic [3:0] burst_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StGap,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] reps_q, reps_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic       x_q, busy_q, done_q;

    // Next-state logic; cnt_q counts elapsed cycles within the current BURST or GAP.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        reps_d  = reps_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bcnt_d = 4'd0;
                    cnt_d  = 4'd0;
                    if (len != 4'd0 && reps != 4'd0) begin
                        len_d   = len;
                        gap_d   = gap;
                        reps_d  = reps;
                        state_d = StBurst;
                    end else begin
                        // Degenerate request: finish without producing any ones.
                        state_d = StDone;
                    end
                end
            end
            StBurst: begin
                if (cnt_q == len_q - 4'd1) begin
                    cnt_d  = 4'd0;
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == reps_q - 4'd1) begin
                        state_d = StDone;
                    end else if (gap_q != 4'd0) begin
                        state_d = StGap;
                    end else begin
                        // Zero gap: stay in BURST so X remains high without a break.
                        state_d = StBurst;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == gap_q - 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StBurst;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched parameters and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            len_q   <= 4'd0;
            gap_q   <= 4'd0;
            reps_q  <= 4'd0;
            cnt_q   <= 4'd0;
            bcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            reps_q  <= reps_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Output flops decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= (state_d == StBurst);
            busy_q <= (state_d == StBurst) || (state_d == StGap);
            done_q <= (state_d == StDone);
        end
    end

    assign X         = x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign burst_cnt = bcnt_q;

endmodule
